// File: rtl/inst_sram_axi_rd_pkg.sv
// Shared definitions for the instruction-side SRAM-like to AXI4 read bridge.
//   AXI_ID_WD       width of the AXI id fields
//   AXI_BURST_INCR  arburst encoding for incrementing bursts
//   AXI_RESP_OKAY   rresp encoding for a good response
//   ar_state_e      states of the AR channel FSM
//   resp_is_err     flags any rresp other than OKAY
package inst_sram_axi_rd_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int AXI_ID_WD = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/inst_sram_axi_rd_outstanding_ctr.sv
// Tracks reads that have been accepted but not yet returned, plus how many
// of the oldest ones must be silently dropped after a flush.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   inc          a request was accepted this cycle
//   dec          an R beat completed this cycle (rvalid & rready & rlast)
//   flush        drop every read accepted before this cycle
//   outstanding  reads accepted and not yet returned
//   discard      oldest returns still to be dropped
//   full         outstanding has reached MAX_OUTSTANDING
//   drop         the R beat completing this cycle belongs to a flushed read
module rd_outstanding_ctr
  import inst_sram_axi_rd_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] outstanding,
  output logic [CNT_W-1:0] discard,
  output logic             full,
  output logic             drop
);

  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] discard_q;

  assign outstanding = outstanding_q;
  assign discard     = discard_q;
  assign full        = (outstanding_q == CNT_W'(MAX_OUTSTANDING));
  assign drop        = dec & (discard_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      // A beat completing in the flush cycle is resolved by its own drop
      // decision, so only the reads still in flight afterwards are dropped.
      // Since discard never exceeds outstanding, this also covers a flush
      // landing while earlier drops are still pending.
      if (flush) begin
        discard_q <= outstanding_q - CNT_W'(dec);
      end else if (drop) begin
        discard_q <= discard_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/inst_sram_axi_rd.sv
// Instruction-side bridge: SRAM-like read slave (req/addr_ok/data_ok) in
// front of an AXI4 read master. Each accepted request issues one single-beat
// AR; responses return in order. A flush drops the responses of every read
// accepted before it while letting the AXI transactions run to completion.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req, wr, size, addr             SRAM-like request (wr=1 never accepted)
//   addr_ok                         request accepted this cycle (combinational)
//   data_ok, rdata, rd_err          registered response; rdata holds between pulses
//   flush                           drop all reads accepted before this cycle
//   ar*                             AXI4 read-address channel (master)
//   rid, rdata_axi, rresp, rlast,
//   rvalid, rready                  AXI4 read-data channel (rready tied high)
module inst_sram_axi_rd
  import inst_sram_axi_rd_pkg::*;
#(
  parameter int                   MAX_OUTSTANDING = 4,
  parameter logic [AXI_ID_WD-1:0] ARID            = 4'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 wr,
  input  logic [1:0]           size,
  input  logic [ADDR_W-1:0]    addr,
  output logic                 addr_ok,
  output logic                 data_ok,
  output logic [DATA_W-1:0]    rdata,
  output logic                 rd_err,
  input  logic                 flush,
  output logic [AXI_ID_WD-1:0] arid,
  output logic [ADDR_W-1:0]    araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic [1:0]           arlock,
  output logic [3:0]           arcache,
  output logic [2:0]           arprot,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [AXI_ID_WD-1:0] rid,
  input  logic [DATA_W-1:0]    rdata_axi,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  ar_state_e        state;
  logic [1:0]       size_q;
  logic             r_hs;
  logic             full;
  logic             drop;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;

  // Responses are in order, so the id is never needed; discard/outstanding
  // are observable for debug only.
  logic unused_sigs;
  assign unused_sigs = &{1'b0, rid, outstanding, discard};

  assign rready = 1'b1;
  assign r_hs   = rvalid & rready & rlast;

  // Only one AR in flight on the channel at a time; the next request is
  // accepted no earlier than the cycle after arready.
  assign addr_ok = req & ~wr & ~flush & (state == AR_IDLE) & ~full;

  rd_outstanding_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .inc        (addr_ok),
    .dec        (r_hs),
    .flush      (flush),
    .outstanding(outstanding),
    .discard    (discard),
    .full       (full),
    .drop       (drop)
  );

  assign arid    = ARID;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // ---- AR channel: request latched on accept, held until arready ----
  // A flush never retracts arvalid; the read is already counted and its
  // response will be dropped by the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= AR_IDLE;
      arvalid <= 1'b0;
      araddr  <= '0;
      size_q  <= 2'b00;
    end else begin
      case (state)
        AR_IDLE: begin
          if (addr_ok) begin
            state   <= AR_SEND;
            arvalid <= 1'b1;
            araddr  <= addr;
            size_q  <= size;
          end
        end
        AR_SEND: begin
          if (arready) begin
            state   <= AR_IDLE;
            arvalid <= 1'b0;
          end
        end
        default: begin
          state   <= AR_IDLE;
          arvalid <= 1'b0;
        end
      endcase
    end
  end

  // ---- R capture: registered response, one cycle after the R handshake ----
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok <= 1'b0;
      rd_err  <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= r_hs & ~drop;
      rd_err  <= r_hs & ~drop & resp_is_err(rresp);
      if (r_hs && !drop) begin
        rdata <= rdata_axi;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_axi_rd.sv
module tb_inst_sram_axi_rd;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        addr_ok, data_ok, rd_err;
  logic [31:0] rdata;
  logic        flush;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata_axi;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int total = 0;
  int bad   = 0;
  int ar_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (arvalid && arready) ar_cnt <= ar_cnt + 1;

  inst_sram_axi_rd #(.MAX_OUTSTANDING(4), .ARID(4'd0)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .rd_err(rd_err),
    .flush(flush), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata_axi(rdata_axi),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read with arready=1: accept cycle then AR handshake cycle.
  task automatic issue(input logic [31:0] a, input string nm);
    req = 1'b1; addr = a; size = 2'd2; arready = 1'b1;
    #1;
    total++;
    if (addr_ok !== 1'b1) begin bad++; $display("FAIL %s addr_ok got=%b exp=1", nm, addr_ok); end
    tick();
    req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 0; wr = 0; size = 0; addr = 0; flush = 0; arready = 0;
    rid = 0; rdata_axi = 0; rresp = 0; rlast = 1; rvalid = 0;
    tick(); tick(); tick();
    total++;
    if ({arvalid, data_ok, rd_err, rdata, araddr} !== 67'd0) begin
      bad++; $display("FAIL reset_state got=%b%b%b %h %h exp=0", arvalid, data_ok, rd_err, rdata, araddr);
    end
    total++;
    if ({rready, arlen, arburst, arid, arlock, arcache, arprot} !== {1'b1, 8'd0, 2'b01, 4'd0, 2'd0, 4'd0, 3'd0}) begin
      bad++; $display("FAIL reset_consts got rready=%b arlen=%h arburst=%b arid=%h", rready, arlen, arburst, arid);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    req = 1'b1; addr = 32'hbfc00000; size = 2'd2; arready = 1'b1;
    #1;
    total++;
    if (addr_ok !== 1'b1) begin bad++; $display("FAIL single_addr_ok got=%b exp=1", addr_ok); end
    tick();
    req = 1'b0;
    total++;
    if (arvalid !== 1'b1 || araddr !== 32'hbfc00000 || arsize !== 3'd2) begin
      bad++; $display("FAIL single_ar got arvalid=%b araddr=%h arsize=%0d exp 1 bfc00000 2", arvalid, araddr, arsize);
    end
    tick();
    rvalid = 1'b1; rdata_axi = 32'h3c1d0000;
    total++;
    if (data_ok !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", data_ok); end
    tick();
    rvalid = 1'b0; rdata_axi = 32'hdeadbeef;
    total++;
    if (data_ok !== 1'b1 || rdata !== 32'h3c1d0000 || rd_err !== 1'b0) begin
      bad++; $display("FAIL single_data got data_ok=%b rdata=%h rd_err=%b exp 1 3c1d0000 0", data_ok, rdata, rd_err);
    end
    tick();
    total++;
    if (data_ok !== 1'b0 || rdata !== 32'h3c1d0000) begin
      bad++; $display("FAIL single_hold got data_ok=%b rdata=%h exp 0 3c1d0000", data_ok, rdata);
    end
  endtask

  task automatic test_ar_stall();
    int ar0;
    ar0 = ar_cnt;
    req = 1'b1; addr = 32'hbfc00100; size = 2'd2; arready = 1'b0;
    tick();
    addr = 32'hbfc00104;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (arvalid !== 1'b1 || araddr !== 32'hbfc00100 || addr_ok !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d got arvalid=%b araddr=%h addr_ok=%b exp 1 bfc00100 0", i, arvalid, araddr, addr_ok);
      end
      tick();
    end
    req = 1'b0; arready = 1'b1;
    tick();
    total++;
    if (arvalid !== 1'b0 || ar_cnt - ar0 != 1) begin
      bad++; $display("FAIL stall_single_ar got arvalid=%b ars=%0d exp 0 1", arvalid, ar_cnt - ar0);
    end
    rvalid = 1'b1; rdata_axi = 32'h11110100;
    tick();
    rvalid = 1'b0;
    total++;
    if (data_ok !== 1'b1 || rdata !== 32'h11110100) begin
      bad++; $display("FAIL stall_data got data_ok=%b rdata=%h exp 1 11110100", data_ok, rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [5];
    d = '{32'ha0000000, 32'ha0000001, 32'ha0000002, 32'ha0000003, 32'ha0000004};
    for (int i = 0; i < 4; i++) issue(32'hbfc00200 + 32'(i*4), "b2b_accept");
    req = 1'b1; addr = 32'hbfc00210;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (addr_ok !== 1'b0) begin bad++; $display("FAIL b2b_full%0d got=%b exp=0", i, addr_ok); end
      tick();
    end
    rvalid = 1'b1; rdata_axi = d[0];
    tick();
    rvalid = 1'b0;
    total++;
    if (data_ok !== 1'b1 || rdata !== d[0]) begin
      bad++; $display("FAIL b2b_first got data_ok=%b rdata=%h exp 1 %h", data_ok, rdata, d[0]);
    end
    total++;
    if (addr_ok !== 1'b1) begin bad++; $display("FAIL b2b_free got=%b exp=1", addr_ok); end
    tick();
    req = 1'b0;
    tick();
    for (int i = 1; i < 5; i++) begin
      rvalid = 1'b1; rdata_axi = d[i];
      tick();
      total++;
      if (data_ok !== 1'b1 || rdata !== d[i]) begin
        bad++; $display("FAIL b2b_order%0d got data_ok=%b rdata=%h exp 1 %h", i, data_ok, rdata, d[i]);
      end
    end
    rvalid = 1'b0;
    tick();
    total++;
    if (data_ok !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", data_ok); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) issue(32'hbfc00300 + 32'(i*4), "flush_accept");
    flush = 1'b1; req = 1'b1; addr = 32'hbfc00380;
    #1;
    total++;
    if (addr_ok !== 1'b0) begin bad++; $display("FAIL flush_addr_ok got=%b exp=0", addr_ok); end
    tick();
    flush = 1'b0; req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rdata_axi = 32'hbad00000 + 32'(i);
      tick();
      total++;
      if (data_ok !== 1'b0 || rdata !== 32'ha0000004) begin
        bad++; $display("FAIL flush_drop%0d got data_ok=%b rdata=%h exp 0 a0000004", i, data_ok, rdata);
      end
    end
    rvalid = 1'b0;
    issue(32'hbfc00380, "flush_new_accept");
    rvalid = 1'b1; rdata_axi = 32'h24080380;
    tick();
    rvalid = 1'b0;
    total++;
    if (data_ok !== 1'b1 || rdata !== 32'h24080380) begin
      bad++; $display("FAIL flush_new got data_ok=%b rdata=%h exp 1 24080380", data_ok, rdata);
    end
  endtask

  task automatic test_flush_with_return();
    issue(32'hbfc00400, "flr_accept");
    issue(32'hbfc00404, "flr_accept");
    flush = 1'b1; rvalid = 1'b1; rdata_axi = 32'he0000000;
    tick();
    flush = 1'b0; rdata_axi = 32'he0000001;
    total++;
    if (data_ok !== 1'b1 || rdata !== 32'he0000000) begin
      bad++; $display("FAIL flr_kept got data_ok=%b rdata=%h exp 1 e0000000", data_ok, rdata);
    end
    tick();
    rvalid = 1'b0;
    total++;
    if (data_ok !== 1'b0 || rdata !== 32'he0000000) begin
      bad++; $display("FAIL flr_dropped got data_ok=%b rdata=%h exp 0 e0000000", data_ok, rdata);
    end
    issue(32'hbfc00408, "flr_after");
    rvalid = 1'b1; rdata_axi = 32'he0000002;
    tick();
    rvalid = 1'b0;
    total++;
    if (data_ok !== 1'b1 || rdata !== 32'he0000002) begin
      bad++; $display("FAIL flr_after got data_ok=%b rdata=%h exp 1 e0000002", data_ok, rdata);
    end
  endtask

  task automatic test_err_and_wr();
    issue(32'hbfc00500, "err_accept");
    rvalid = 1'b1; rresp = 2'b10; rdata_axi = 32'h55aa55aa;
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    total++;
    if (data_ok !== 1'b1 || rd_err !== 1'b1 || rdata !== 32'h55aa55aa) begin
      bad++; $display("FAIL err_resp got data_ok=%b rd_err=%b rdata=%h exp 1 1 55aa55aa", data_ok, rd_err, rdata);
    end
    tick();
    total++;
    if (rd_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", rd_err); end
    req = 1'b1; wr = 1'b1; addr = 32'hbfc00600;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (addr_ok !== 1'b0 || arvalid !== 1'b0) begin
        bad++; $display("FAIL wr_reject%0d got addr_ok=%b arvalid=%b exp 0 0", i, addr_ok, arvalid);
      end
      tick();
    end
    req = 1'b0; wr = 1'b0;
  endtask

  task automatic test_mid_reset();
    req = 1'b1; addr = 32'hbfc00700; arready = 1'b0;
    tick();
    req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (arvalid !== 1'b0 || araddr !== 32'd0 || data_ok !== 1'b0) begin
      bad++; $display("FAIL midreset got arvalid=%b araddr=%h data_ok=%b exp 0 0 0", arvalid, araddr, data_ok);
    end
    issue(32'hbfc00704, "midreset_accept");
    rvalid = 1'b1; rdata_axi = 32'h77770704;
    tick();
    rvalid = 1'b0;
    total++;
    if (data_ok !== 1'b1 || rdata !== 32'h77770704) begin
      bad++; $display("FAIL midreset_read got data_ok=%b rdata=%h exp 1 77770704", data_ok, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_ar_stall();
    test_back_to_back();
    test_flush();
    test_flush_with_return();
    test_err_and_wr();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
